// File: rtl/frag_pkg.sv
// Shared types and constants for the fragment splitter: FSM states, buffer sizing and
// byte-mask helpers used by both the top level and the extraction datapath.
package frag_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int unsigned BUF_BYTES = 8;
    localparam int unsigned MAX_FRAG  = 4;

    // Mask keeping the top n bytes of an MSB-aligned word.
    function automatic logic [31:0] byte_mask(input logic [2:0] n);
        case (n)
            3'd0:    return 32'h0000_0000;
            3'd1:    return 32'hFF00_0000;
            3'd2:    return 32'hFFFF_0000;
            3'd3:    return 32'hFFFF_FF00;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    function automatic logic [2:0] norm_flen(input logic [2:0] len);
        return (len >= 3'd1 && len <= 3'(MAX_FRAG)) ? len : 3'(MAX_FRAG);
    endfunction

endpackage

// File: rtl/frag_splitter_if.sv
// Valid/ready byte-stream bus: MSB-aligned data word, byte count and end-of-frame flag.
interface frag_splitter_if;
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        last;
    logic        valid;
    logic        ready;

    modport master (output data, bytes, last, valid, input ready);
    modport slave  (input data, bytes, last, valid, output ready);
endinterface

// File: rtl/frag_extract.sv
// Combinational datapath: pulls the head bytes out of the staging buffer, compacts what is
// left toward the head and appends the incoming word's valid bytes behind it.
module frag_extract
    import frag_pkg::*;
(
    input  logic [BUF_BYTES*8-1:0] i_buf,
    input  logic [3:0]             i_cnt,
    input  logic [2:0]             i_take,
    input  logic [31:0]            i_data,
    input  logic [2:0]             i_in_bytes,
    output logic [31:0]            o_head,
    output logic [BUF_BYTES*8-1:0] o_buf_next
);

    logic [3:0]             w_rem;
    logic [BUF_BYTES*8-1:0] w_shifted;
    logic [BUF_BYTES*8-1:0] w_incoming;

    // Bytes beyond cnt are always zero, so OR-merging the shifted parts is safe.
    always_comb begin
        o_head     = i_buf[BUF_BYTES*8-1 -: 32] & byte_mask(i_take);
        w_shifted  = i_buf << {i_take, 3'b000};
        w_rem      = i_cnt - {1'b0, i_take};
        w_incoming = {i_data & byte_mask(i_in_bytes), {(BUF_BYTES*8-32){1'b0}}}
                     >> {w_rem, 3'b000};
        o_buf_next = w_shifted | w_incoming;
    end

endmodule

// File: rtl/frag_splitter.sv
// Re-chunks an MSB-aligned byte stream into fragments of a per-frame size (1-4 bytes),
// through an 8-byte staging buffer and a 1-deep registered output stage.
module frag_splitter
    import frag_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2:0]            frag_len,
    frag_splitter_if.slave        s,
    frag_splitter_if.master       m
);

    state_t                 r_state;
    logic [BUF_BYTES*8-1:0] r_buf;
    logic [3:0]             r_cnt;
    logic [2:0]             r_flen;
    logic [31:0]            r_m_data;
    logic [2:0]             r_m_bytes;
    logic                   r_m_last;
    logic                   r_m_valid;

    logic                   w_s_ready;
    logic                   w_accept;
    logic [2:0]             w_in_bytes;
    logic                   w_out_free;
    logic                   w_load;
    logic [2:0]             w_load_bytes;
    logic                   w_load_last;
    logic [31:0]            w_head;
    logic [BUF_BYTES*8-1:0] w_buf_next;
    logic [3:0]             w_cnt_next;
    logic [3:0]             w_flen;

    assign w_s_ready  = (r_state != DRAIN) && (r_cnt <= 4'd4);
    assign w_accept   = s.valid && w_s_ready;
    // Words with an illegal byte count are accepted but contribute nothing.
    assign w_in_bytes = (w_accept && s.bytes != 3'd0 && s.bytes <= 3'(MAX_FRAG)) ? s.bytes : 3'd0;
    assign w_out_free = !r_m_valid || m.ready;
    assign w_flen     = {1'b0, r_flen};

    always_comb begin
        w_load       = 1'b0;
        w_load_bytes = 3'd0;
        w_load_last  = 1'b0;
        if (w_out_free && r_cnt != 4'd0) begin
            if (r_state == DRAIN && r_cnt <= w_flen) begin
                w_load       = 1'b1;
                w_load_bytes = r_cnt[2:0];
                w_load_last  = 1'b1;
            end else if (r_cnt >= w_flen) begin
                w_load       = 1'b1;
                w_load_bytes = r_flen;
            end
        end
    end

    assign w_cnt_next = r_cnt + {1'b0, w_in_bytes} - {1'b0, w_load_bytes};

    frag_extract u_extract (
        .i_buf      (r_buf),
        .i_cnt      (r_cnt),
        .i_take     (w_load_bytes),
        .i_data     (s.data),
        .i_in_bytes (w_in_bytes),
        .o_head     (w_head),
        .o_buf_next (w_buf_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_buf     <= '0;
            r_cnt     <= 4'd0;
            r_flen    <= 3'd0;
            r_m_data  <= 32'd0;
            r_m_bytes <= 3'd0;
            r_m_last  <= 1'b0;
            r_m_valid <= 1'b0;
        end else begin
            r_buf <= w_buf_next;
            r_cnt <= w_cnt_next;
            if (w_load) begin
                r_m_data  <= w_head;
                r_m_bytes <= w_load_bytes;
                r_m_last  <= w_load_last;
                r_m_valid <= 1'b1;
            end else if (m.ready) begin
                r_m_valid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_flen  <= norm_flen(frag_len);
                        r_state <= s.last ? DRAIN : RUN;
                    end
                end
                RUN: begin
                    if (w_accept && s.last) r_state <= DRAIN;
                end
                DRAIN: begin
                    // Leave only once nothing is buffered and the output stage has emptied.
                    if (r_cnt == 4'd0 && w_out_free) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s.ready = w_s_ready;
    assign m.data  = r_m_data;
    assign m.bytes = r_m_bytes;
    assign m.last  = r_m_last;
    assign m.valid = r_m_valid;

endmodule
